// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data SRAM port arbiter with starvation guard
module mem_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        mem_clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [29:0] if_pc,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_select,
  output logic [29:0] mem_d_pc,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_wren,
  input  logic [31:0] mem_q
);

  typedef enum logic {
    NORMAL   = 1'b0,
    FORCE_IF = 1'b1
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [3:0] w_cnt_inc;
  logic       w_if_gnt;
  logic       w_d_gnt;
  logic       r_pend_if;
  logic       r_pend_d;

  assign w_cnt_inc = r_cnt + 4'd1;

  // Arbiter state and starvation counter; reset forces data-priority mode
  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      r_state <= NORMAL;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Grant selection and next-state: data wins unless fetch is owed a turn
  always_comb begin
    w_if_gnt    = 1'b0;
    w_d_gnt     = 1'b0;
    w_state_nxt = NORMAL;
    w_cnt_nxt   = 4'd0;
    if (!reset) begin
      if (r_state == FORCE_IF && if_req) begin
        w_if_gnt = 1'b1;
      end else if (d_req) begin
        w_d_gnt = 1'b1;
      end else if (if_req) begin
        w_if_gnt = 1'b1;
      end
      // A lost fetch cycle counts toward the limit; reaching it owes fetch the next cycle
      if (if_req && !w_if_gnt) begin
        if (w_cnt_inc == LIMIT) begin
          w_state_nxt = FORCE_IF;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
    end
  end

  // Remember which requester owns the read data returning next cycle
  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      r_pend_if <= 1'b0;
      r_pend_d  <= 1'b0;
    end else begin
      r_pend_if <= w_if_gnt;
      r_pend_d  <= w_d_gnt & ~d_we;
    end
  end

  assign if_gnt     = w_if_gnt;
  assign d_gnt      = w_d_gnt;
  assign mem_select = ~w_d_gnt;
  assign mem_wren   = w_d_gnt & d_we;
  assign mem_d_pc   = if_pc;
  assign mem_addr   = d_addr;
  assign mem_data   = d_wdata;
  assign if_rvalid  = r_pend_if;
  assign d_rvalid   = r_pend_d;
  assign if_rdata   = mem_q;
  assign d_rdata    = mem_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int LIMIT = 3;

  logic        mem_clk;
  logic        reset;
  logic        if_req;
  logic [29:0] if_pc;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_select;
  logic [29:0] mem_d_pc;
  logic [29:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .mem_clk(mem_clk), .reset(reset),
    .if_req(if_req), .if_pc(if_pc), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_select(mem_select), .mem_d_pc(mem_d_pc), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  // SRAM with registered address: data appears one cycle after the address
  logic [31:0] sram [256];
  always @(posedge mem_clk) begin
    mem_q <= sram[mem_select ? mem_d_pc[7:0] : mem_addr[7:0]];
    if (mem_wren) sram[mem_addr[7:0]] = mem_data;
  end

  // Reference model: expected memory contents, fairness bookkeeping, returning reads
  logic [31:0] ref_mem [256];
  int          m_losses;
  bit          m_owed;
  bit          exp_ifv, exp_dv;
  logic [31:0] exp_ifdata, exp_ddata;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 ^ (i * 32'h0001_0203);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_losses = 0;
    m_owed   = 0;
    exp_ifv  = 0;
    exp_dv   = 0;
  endtask

  // One clock cycle: apply inputs at the falling edge, check, advance the model
  task automatic cycle(input bit ifr, input logic [29:0] pc, input bit dr, input bit we,
                       input logic [29:0] da, input logic [31:0] wd, output int g);
    if_req = ifr; if_pc = pc; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
    #1;
    if (!ifr && !dr)               g = 0;
    else if (ifr && (m_owed || !dr)) g = 1;
    else                           g = 2;
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, g == 1});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, g == 2});
    chk("mem_select", {31'd0, mem_select}, {31'd0, g != 2});
    chk("mem_wren", {31'd0, mem_wren}, {31'd0, g == 2 && we});
    chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, exp_ifv});
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, exp_dv});
    if (exp_ifv) chk("if_rdata", if_rdata, exp_ifdata);
    if (exp_dv)  chk("d_rdata", d_rdata, exp_ddata);
    chk("mem_addr_pass", {2'b0, mem_addr}, {2'b0, da});
    exp_ifv    = (g == 1);
    exp_ifdata = ref_mem[pc[7:0]];
    exp_dv     = (g == 2) && !we;
    exp_ddata  = ref_mem[da[7:0]];
    if (g == 2 && we) ref_mem[da[7:0]] = wd;
    if (ifr && g != 1) begin
      if (m_losses + 1 == LIMIT) begin
        m_owed = 1; m_losses = 0;
      end else begin
        m_owed = 0; m_losses++;
      end
    end else begin
      m_owed = 0; m_losses = 0;
    end
    @(negedge mem_clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_if_gnt"}, {31'd0, if_gnt}, 32'd0);
    chk({tag, "_d_gnt"}, {31'd0, d_gnt}, 32'd0);
    chk({tag, "_wren"}, {31'd0, mem_wren}, 32'd0);
    chk({tag, "_select"}, {31'd0, mem_select}, 32'd1);
    chk({tag, "_if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
    chk({tag, "_d_rvalid"}, {31'd0, d_rvalid}, 32'd0);
  endtask

  int g;
  int pat [8];
  bit          r_ifr, r_dr, r_we;
  logic [29:0] r_pc, r_da;
  logic [31:0] r_wd;

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]    = init_word(i);
      ref_mem[i] = init_word(i);
    end
    model_reset();
    reset = 1'b1;
    if_req = 1'b1; if_pc = 30'h10; d_req = 1'b1; d_we = 1'b1; d_addr = 30'h20; d_wdata = 32'h0;
    @(negedge mem_clk);
    @(negedge mem_clk);
    chk_reset_outputs("reset");
    reset = 1'b0;

    // Fetch alone, then store and load-back of the same word
    cycle(1, 30'h10, 0, 0, 30'h0, 32'h0, g);
    cycle(0, 30'h10, 1, 1, 30'h20, 32'hDEADBEEF, g);
    cycle(0, 30'h10, 1, 0, 30'h20, 32'h0, g);
    cycle(0, 30'h10, 0, 0, 30'h20, 32'h0, g);
    chk("store_then_load", ref_mem[8'h20], 32'hDEADBEEF);

    // Both requesting continuously: fetch must win every LIMIT+1 cycles
    for (int i = 0; i < 8; i++) begin
      cycle(1, 30'h11, 1, 0, 30'h21, 32'h0, g);
      pat[i] = g;
    end
    for (int i = 0; i < 8; i++)
      chk("starve_pattern", pat[i], (i % 4 == 3) ? 1 : 2);

    // Alternating load / fetch every cycle
    for (int i = 0; i < 6; i++)
      cycle(i % 2 == 1, 30'(8'h30 + i), i % 2 == 0, 0, 30'(8'h40 + i), 32'h0, g);

    // Starve fetch twice, load granted, then reset pulsed in the following cycle
    cycle(1, 30'h12, 1, 0, 30'h22, 32'h0, g);
    cycle(1, 30'h12, 1, 0, 30'h22, 32'h0, g);
    if_req = 1; d_req = 1; d_we = 1;
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    @(negedge mem_clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 30'h13, 1, 0, 30'h23, 32'h0, g);
      chk("post_reset_pattern", g, (i == 3) ? 1 : 2);
    end

    // Idle
    for (int i = 0; i < 6; i++) cycle(0, 30'h0, 0, 0, 30'h0, 32'h0, g);

    // Randomized traffic obeying hold-until-grant
    r_ifr = 0; r_dr = 0; r_we = 0; r_pc = 0; r_da = 0; r_wd = 0;
    for (int n = 0; n < 400; n++) begin
      if (!r_ifr && $urandom_range(0, 2) != 0) begin
        r_ifr = 1; r_pc = 30'($urandom_range(0, 15));
      end
      if (!r_dr && $urandom_range(0, 2) != 0) begin
        r_dr = 1; r_we = 1'($urandom_range(0, 1));
        r_da = 30'($urandom_range(0, 15)); r_wd = $urandom;
      end
      cycle(r_ifr, r_pc, r_dr, r_we, r_da, r_wd, g);
      if (g == 1) r_ifr = 0;
      if (g == 2) r_dr = 0;
    end
    cycle(0, 30'h0, 0, 0, 30'h0, 32'h0, g);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
